// File: rtl/jtag_pkg.sv
// jtag_pkg: shared definitions for the JTAG master sequencer.
//   - command opcode and controller state encodings
//   - TMS prefix/suffix patterns (bit 0 is driven first) and their lengths
//   - helpers that give the TMS level and the shift window for a TCK cycle index
package jtag_pkg;

  localparam int unsigned MAX_BITS_DEF = 32;

  typedef enum logic [1:0] {
    OP_TAP_RESET = 2'b00,
    OP_SHIFT_IR  = 2'b01,
    OP_SHIFT_DR  = 2'b10,
    OP_IDLE_CLK  = 2'b11
  } jtag_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } jtag_state_e;

  // Prefix patterns all start from Run-Test/Idle.
  localparam logic [7:0] TMS_PRE_RESET = 8'b0001_1111;  // 1,1,1,1,1,0
  localparam logic [7:0] TMS_PRE_IR    = 8'b0000_0011;  // 1,1,0,0
  localparam logic [7:0] TMS_PRE_DR    = 8'b0000_0001;  // 1,0,0
  localparam logic [5:0] LEN_PRE_RESET = 6'd6;
  localparam logic [5:0] LEN_PRE_IR    = 6'd4;
  localparam logic [5:0] LEN_PRE_DR    = 6'd3;
  // Suffix after Exit1: Update (1) then Run-Test/Idle (0).
  localparam logic [1:0] TMS_SUF       = 2'b01;
  localparam logic [5:0] LEN_SUF       = 6'd2;

  function automatic logic [7:0] pre_tms(input jtag_op_e op);
    logic [7:0] r;
    case (op)
      OP_TAP_RESET: r = TMS_PRE_RESET;
      OP_SHIFT_IR:  r = TMS_PRE_IR;
      OP_SHIFT_DR:  r = TMS_PRE_DR;
      default:      r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [5:0] pre_len(input jtag_op_e op);
    logic [5:0] r;
    case (op)
      OP_TAP_RESET: r = LEN_PRE_RESET;
      OP_SHIFT_IR:  r = LEN_PRE_IR;
      OP_SHIFT_DR:  r = LEN_PRE_DR;
      default:      r = 6'd0;
    endcase
    return r;
  endfunction

  function automatic logic [5:0] suf_len(input jtag_op_e op);
    logic [5:0] r;
    if ((op == OP_SHIFT_IR) || (op == OP_SHIFT_DR)) r = LEN_SUF;
    else r = 6'd0;
    return r;
  endfunction

  // Number of shift/idle cycles; TAP reset has no shift window.
  function automatic logic [5:0] shift_len(input jtag_op_e op, input logic [4:0] len);
    logic [5:0] r;
    if (op == OP_TAP_RESET) r = 6'd0;
    else r = {1'b0, len} + 6'd1;
    return r;
  endfunction

  // True when TCK cycle 'cyc' moves a data bit through IR or DR.
  function automatic logic is_shift(input jtag_op_e op, input logic [5:0] cyc,
                                    input logic [5:0] n);
    logic [5:0] pl;
    logic       r;
    pl = pre_len(op);
    if ((op == OP_SHIFT_IR) || (op == OP_SHIFT_DR)) r = (cyc >= pl) && ((cyc - pl) < n);
    else r = 1'b0;
    return r;
  endfunction

  // TMS level for TCK cycle 'cyc': prefix, shift window (last bit exits), suffix.
  function automatic logic tms_bit(input jtag_op_e op, input logic [5:0] cyc,
                                   input logic [5:0] n);
    logic [7:0] pre;
    logic [5:0] pl;
    logic [5:0] rel;
    logic [5:0] rel_suf;
    logic       r;
    pre     = pre_tms(op);
    pl      = pre_len(op);
    rel     = cyc - pl;
    rel_suf = rel - n;
    if (cyc < pl) r = pre[cyc[2:0]];
    else if (rel < n) r = (op != OP_IDLE_CLK) && (rel == (n - 6'd1));
    else r = (rel_suf == 6'd0) ? TMS_SUF[0] : TMS_SUF[1];
    return r;
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// jtag_tck_gen: TCK divider. While en_i is high the divider counts
// 0..CLK_DIV-1 and ticks on the terminal count; each tick toggles TCK, so one
// TCK period is a low phase then a high phase of CLK_DIV clocks each.
// Ports: clk_i/rst_ni clock and async active-low reset; en_i run enable
// (divider and TCK held at 0 when low); tck_o registered TCK; rise_o/fall_o
// one-clock strobes on the tick that raises/lowers TCK.
module jtag_tck_gen
  import jtag_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic tck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned    DW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0]  DIV_ONE  = DW'(1);

  logic [DW-1:0] div_q, div_d;
  logic          tck_q, tck_d;
  logic          tick_s;

  // Divider next state and TCK toggle on terminal count.
  always_comb begin
    tick_s = en_i && (div_q == DIV_LAST);
    if (!en_i) begin
      div_d = {DW{1'b0}};
      tck_d = 1'b0;
    end else if (tick_s) begin
      div_d = {DW{1'b0}};
      tck_d = ~tck_q;
    end else begin
      div_d = div_q + DIV_ONE;
      tck_d = tck_q;
    end
  end

  // Divider and TCK registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= {DW{1'b0}};
      tck_q <= 1'b0;
    end else begin
      div_q <= div_d;
      tck_q <= tck_d;
    end
  end

  assign tck_o  = tck_q;
  assign rise_o = tick_s & ~tck_q;
  assign fall_o = tick_s & tck_q;

endmodule

// File: rtl/jtag_master_ctrl.sv
// jtag_master_ctrl: command-driven JTAG chain sequencer.
// Ports: clk/resetb (async active-low); cmd_valid/cmd_ready/cmd_op/cmd_len/
// cmd_data command handshake (len = count-1, data LSB first); rsp_valid one
// clock pulse with rsp_data (captured TDO, held until the next completion);
// tck/tms/tdi JTAG drive, tdo JTAG return.
// Build option JTAG_LOOPBACK_EN: when defined, the capture path samples the
// internal TDI register instead of the tdo pin (self-test).
// TMS/TDI change only on the tick that lowers TCK (or at acceptance), TDO is
// sampled on the tick that raises TCK.
module jtag_master_ctrl
  import jtag_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned MAX_BITS = MAX_BITS_DEF
) (
  input  logic                clk,
  input  logic                resetb,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [4:0]          cmd_len,
  input  logic [MAX_BITS-1:0] cmd_data,
  output logic                rsp_valid,
  output logic [MAX_BITS-1:0] rsp_data,
  output logic                tck,
  output logic                tms,
  output logic                tdi,
  input  logic                tdo
);

  localparam int unsigned IW = $clog2(MAX_BITS);

  jtag_state_e         state_q, state_d;
  jtag_op_e            op_q, op_d, cmd_op_s;
  logic [5:0]          n_q, n_d, cyc_q, cyc_d, cyc_nxt_s, total_s, cmd_n_s;
  logic [MAX_BITS-1:0] data_q, data_d, cap_q, cap_d, rsp_data_q, rsp_data_d;
  logic                tms_q, tms_d, tdi_q, tdi_d;
  logic                ready_q, ready_d, rsp_valid_q, rsp_valid_d;
  logic                run_s, rise_s, fall_s, accept_s, last_s, sample_s;
  logic [IW-1:0]       idx_s, idx_nxt_s;

  assign run_s = (state_q == ST_RUN);

  jtag_tck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tck_gen (
    .clk_i  (clk),
    .rst_ni (resetb),
    .en_i   (run_s),
    .tck_o  (tck),
    .rise_o (rise_s),
    .fall_o (fall_s)
  );

`ifdef JTAG_LOOPBACK_EN
  assign sample_s = tdi_q;
`else
  assign sample_s = tdo;
`endif

  // Command decode and TCK cycle bookkeeping.
  always_comb begin
    cmd_op_s  = jtag_op_e'(cmd_op);
    cmd_n_s   = shift_len(cmd_op_s, cmd_len);
    accept_s  = cmd_valid && ready_q;
    total_s   = pre_len(op_q) + n_q + suf_len(op_q);
    last_s    = (cyc_q == (total_s - 6'd1));
    cyc_nxt_s = cyc_q + 6'd1;
    idx_s     = IW'(cyc_q - pre_len(op_q));
    idx_nxt_s = IW'(cyc_nxt_s - pre_len(op_q));
  end

  // Controller FSM: accept, step TMS/TDI per TCK cycle, capture TDO, complete.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    n_d         = n_q;
    cyc_d       = cyc_q;
    data_d      = data_q;
    cap_d       = cap_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          state_d = ST_RUN;
          op_d    = cmd_op_s;
          n_d     = cmd_n_s;
          cyc_d   = 6'd0;
          data_d  = cmd_data;
          cap_d   = {MAX_BITS{1'b0}};
          tms_d   = tms_bit(cmd_op_s, 6'd0, cmd_n_s);
          tdi_d   = 1'b0;  // no op shifts in its first TCK cycle
          ready_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (rise_s) begin
          if (is_shift(op_q, cyc_q, n_q)) cap_d[idx_s] = sample_s;
          else cap_d = cap_q;
        end else if (fall_s) begin
          if (last_s) begin
            state_d     = ST_DONE;
            ready_d     = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_data_d  = cap_q;
            tdi_d       = 1'b0;
          end else begin
            cyc_d = cyc_nxt_s;
            tms_d = tms_bit(op_q, cyc_nxt_s, n_q);
            tdi_d = is_shift(op_q, cyc_nxt_s, n_q) ? data_q[idx_nxt_s] : 1'b0;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // Controller state and output registers.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_TAP_RESET;
      n_q         <= 6'd0;
      cyc_q       <= 6'd0;
      data_q      <= {MAX_BITS{1'b0}};
      cap_q       <= {MAX_BITS{1'b0}};
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= {MAX_BITS{1'b0}};
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      n_q         <= n_d;
      cyc_q       <= cyc_d;
      data_q      <= data_d;
      cap_q       <= cap_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cmd_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;

endmodule

// File: tb/tb_jtag_master_ctrl.sv
// Testbench for jtag_master_ctrl: table of directed commands with
// hand-computed TMS/TDI sequences, TCK counts, latencies and responses, run
// against a behavioural TAP (8-bit IR capturing 0x01, 32-bit IDCODE DR),
// plus hand sequences for reset abort and busy-time command holding.
module tb_jtag_master_ctrl;

  localparam int CLK_DIV = 4;
  localparam int HIST    = 1024;
  localparam logic [31:0] IDCODE = 32'h5960_8093;
  localparam logic [7:0]  IR_CAP = 8'h01;

  logic        clk = 1'b0;
  logic        resetb;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_len;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        tck, tms, tdi;
  logic        tdo_m = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  jtag_master_ctrl #(
    .CLK_DIV  (CLK_DIV),
    .MAX_BITS (32)
  ) dut (
    .clk       (clk),
    .resetb    (resetb),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .tck       (tck),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo_m)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural TAP model ----------------
  typedef enum logic [3:0] {
    TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
    SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR
  } tap_e;

  tap_e        tap_st = TLR;
  logic [31:0] dr_sr  = 32'h0;
  logic [7:0]  ir_sr  = 8'h0;
  int          tck_total = 0;
  logic        tms_hist [0:HIST-1];
  logic        tdi_hist [0:HIST-1];

  function automatic tap_e tap_next(input tap_e s, input logic m);
    tap_e r;
    case (s)
      TLR:     r = m ? TLR   : RTI;
      RTI:     r = m ? SELDR : RTI;
      SELDR:   r = m ? SELIR : CAPDR;
      CAPDR:   r = m ? EX1DR : SHDR;
      SHDR:    r = m ? EX1DR : SHDR;
      EX1DR:   r = m ? UPDR  : PADR;
      PADR:    r = m ? EX2DR : PADR;
      EX2DR:   r = m ? UPDR  : SHDR;
      UPDR:    r = m ? SELDR : RTI;
      SELIR:   r = m ? TLR   : CAPIR;
      CAPIR:   r = m ? EX1IR : SHIR;
      SHIR:    r = m ? EX1IR : SHIR;
      EX1IR:   r = m ? UPIR  : PAIR;
      PAIR:    r = m ? EX2IR : PAIR;
      EX2IR:   r = m ? UPIR  : SHIR;
      UPIR:    r = m ? SELDR : RTI;
      default: r = TLR;
    endcase
    return r;
  endfunction

  always @(posedge tck) begin
    if (tck_total < HIST) begin
      tms_hist[tck_total] <= tms;
      tdi_hist[tck_total] <= tdi;
    end
    tck_total <= tck_total + 1;
    case (tap_st)
      CAPDR:   dr_sr <= IDCODE;
      SHDR:    dr_sr <= {tdi, dr_sr[31:1]};
      CAPIR:   ir_sr <= IR_CAP;
      SHIR:    ir_sr <= {tdi, ir_sr[7:1]};
      default: ;
    endcase
    tap_st <= tap_next(tap_st, tms);
  end

  always @(negedge tck) begin
    tdo_m <= (tap_st == SHDR) ? dr_sr[0] : ((tap_st == SHIR) ? ir_sr[0] : 1'b0);
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input int tag, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, tag, act, exp);
    end
  endtask

  // Present one command for a single accepting edge, then wait for rsp_valid.
  task automatic issue(input logic [1:0] op, input logic [4:0] len,
                       input logic [31:0] data, input int tag, output int lat);
    @(negedge clk);
    chk("ready_before", tag, 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    cmd_data  = data;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("ready_busy", tag, 64'(cmd_ready), 64'd0);
    lat = 1;
    while (!rsp_valid && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic seq_hist(input int base, input int n, output logic [63:0] t_m,
                          output logic [63:0] t_d);
    t_m = 64'd0;
    t_d = 64'd0;
    for (int c = 0; c < n && c < 64 && (base + c) < HIST; c++) begin
      t_m[c] = tms_hist[base + c];
      t_d[c] = tdi_hist[base + c];
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  len;
    logic [31:0] data;
    int          tck_n;
    logic [63:0] tms_seq;
    logic [63:0] tdi_seq;
    logic [31:0] rsp;
    logic [31:0] rsp_lb;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int          lat;
    int          base;
    int          pulses;
    logic [31:0] exp_rsp;
    logic [63:0] a_tms, a_tdi;

    vecs[0] = '{2'b00, 5'd0,  32'h0000_0000, 6,  64'h1F,           64'h0,       32'h0,          32'h0};
    vecs[1] = '{2'b01, 5'd7,  32'h0000_00A5, 14, 64'h1803,         64'hA50,     32'h0000_0001,  32'h0000_00A5};
    vecs[2] = '{2'b10, 5'd31, 32'h0000_0000, 37, 64'hC_0000_0001,  64'h0,       32'h5960_8093,  32'h0};
    vecs[3] = '{2'b11, 5'd9,  32'hFFFF_FFFF, 10, 64'h0,            64'h0,       32'h0,          32'h0};
    vecs[4] = '{2'b10, 5'd15, 32'hDEAD_BEEF, 21, 64'hC_0001,       64'h5_F778,  32'h0000_8093,  32'h0000_BEEF};
    vecs[5] = '{2'b01, 5'd3,  32'h0000_0006, 10, 64'h183,          64'h60,      32'h0000_0001,  32'h0000_0006};
    vecs[6] = '{2'b10, 5'd0,  32'h0000_0001, 6,  64'h19,           64'h8,       32'h0000_0001,  32'h0000_0001};

    resetb    = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_len   = 5'd0;
    cmd_data  = 32'h0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_tck", 0, 64'(tck), 64'd0);
    chk("rst_tms", 0, 64'(tms), 64'd1);
    chk("rst_tdi", 0, 64'(tdi), 64'd0);
    chk("rst_ready", 0, 64'(cmd_ready), 64'd1);
    chk("rst_rsp_valid", 0, 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 0, 64'(rsp_data), 64'd0);
    resetb = 1'b1;

    // Reset in the middle of a DR shift aborts without a response.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_len   = 5'd31;
    cmd_data  = 32'hFFFF_FFFF;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (100) @(negedge clk);
    chk("abort_running", 0, 64'(cmd_ready), 64'd0);
    resetb = 1'b0;
    #1;
    chk("abort_tck", 0, 64'(tck), 64'd0);
    chk("abort_tms", 0, 64'(tms), 64'd1);
    chk("abort_tdi", 0, 64'(tdi), 64'd0);
    chk("abort_ready", 0, 64'(cmd_ready), 64'd1);
    chk("abort_rsp_valid", 0, 64'(rsp_valid), 64'd0);
    @(negedge clk);
    resetb = 1'b1;
    base   = tck_total;
    pulses = 0;
    repeat (60) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    chk("abort_no_rsp", 0, 64'(pulses), 64'd0);
    chk("abort_no_tck", 0, 64'(tck_total - base), 64'd0);

    // Directed command table (first entry is the TAP reset after abort).
    for (int i = 0; i < 7; i++) begin
`ifdef JTAG_LOOPBACK_EN
      exp_rsp = vecs[i].rsp_lb;
`else
      exp_rsp = vecs[i].rsp;
`endif
      base = tck_total;
      issue(vecs[i].op, vecs[i].len, vecs[i].data, i, lat);
      chk("rsp_seen", i, 64'(rsp_valid), 64'd1);
      chk("latency", i, 64'(lat), 64'(2 * CLK_DIV * vecs[i].tck_n + 1));
      chk("rsp_data", i, 64'(rsp_data), 64'(exp_rsp));
      chk("ready_done", i, 64'(cmd_ready), 64'd1);
      chk("tck_idle", i, 64'(tck), 64'd0);
      chk("tck_count", i, 64'(tck_total - base), 64'(vecs[i].tck_n));
      seq_hist(base, vecs[i].tck_n, a_tms, a_tdi);
      chk("tms_seq", i, a_tms, vecs[i].tms_seq);
      chk("tdi_seq", i, a_tdi, vecs[i].tdi_seq);
      chk("tap_rti", i, 64'(tap_st), 64'(RTI));
      @(negedge clk);
      chk("rsp_pulse", i, 64'(rsp_valid), 64'd0);
      chk("rsp_hold", i, 64'(rsp_data), 64'(exp_rsp));
    end

    // Idle clocks with cmd_valid held throughout; the held command (TAP
    // reset) is accepted only in the response cycle.
    base = tck_total;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_len   = 5'd9;
    cmd_data  = 32'hFFFF_FFFF;
    @(negedge clk);
    cmd_op    = 2'b00;
    cmd_len   = 5'd0;
    lat = 1;
    while (!rsp_valid && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    chk("hold_rsp_seen", 0, 64'(rsp_valid), 64'd1);
    chk("hold_latency", 0, 64'(lat), 64'(2 * CLK_DIV * 10 + 1));
    chk("hold_ready", 0, 64'(cmd_ready), 64'd1);
    chk("hold_tck_count", 0, 64'(tck_total - base), 64'd10);
    seq_hist(base, 10, a_tms, a_tdi);
    chk("hold_tms_zero", 0, a_tms, 64'd0);
    chk("hold_tdi_zero", 0, a_tdi, 64'd0);
    base = tck_total;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("second_accepted", 1, 64'(cmd_ready), 64'd0);
    lat = 1;
    while (!rsp_valid && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    chk("second_rsp_seen", 1, 64'(rsp_valid), 64'd1);
    chk("second_latency", 1, 64'(lat), 64'(2 * CLK_DIV * 6 + 1));
    chk("second_tck_count", 1, 64'(tck_total - base), 64'd6);
    seq_hist(base, 6, a_tms, a_tdi);
    chk("second_tms_seq", 1, a_tms, 64'h1F);
    chk("second_tap_rti", 1, 64'(tap_st), 64'(RTI));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d compares so far", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
